// File: rtl/tick_period_monitor.sv
// -----------------------------------------------------------------------------
// tick_period_monitor
//   Receive-side checker for single-cycle tick strobes coming from a clock
//   divider in the same clock domain. Measures the clk-cycle spacing between
//   ticks, reports each measured period, flags early ticks and late/missing
//   ticks, and asserts locked after LOCK_COUNT consecutive in-window periods.
//
// Parameters
//   EXP_PERIOD  expected tick spacing in clk cycles (>= 2)
//   TOL         allowed +/- deviation in cycles (< EXP_PERIOD)
//   LOCK_COUNT  consecutive good periods required to assert locked (>= 1)
//   CNT_W       period counter width (2**CNT_W > EXP_PERIOD+TOL)
//
// Ports
//   clk           in   1      system clock, rising edge
//   reset_n       in   1      asynchronous active-low reset
//   enable        in   1      monitor enable, low forces IDLE
//   tick_in       in   1      tick strobe, one cycle high per tick
//   period        out  CNT_W  last measured period (holds between reports)
//   period_valid  out  1      one-cycle pulse, period updated
//   locked        out  1      high while tick stream is in window
//   err_early     out  1      one-cycle pulse, period < EXP_PERIOD-TOL
//   err_late      out  1      one-cycle pulse, no tick by EXP_PERIOD+TOL
//   err_clr       in   1      (TICK_ERR_CNT_EN only) synchronous error count clear
//   err_cnt       out  8      (TICK_ERR_CNT_EN only) saturating error count
//
// Optional feature macro: TICK_ERR_CNT_EN adds the err_clr/err_cnt error counter.
// -----------------------------------------------------------------------------
module tick_period_monitor #(
  parameter int EXP_PERIOD = 3,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err_early,
  output logic             err_late
`ifdef TICK_ERR_CNT_EN
  ,
  input  logic             err_clr,
  output logic [7:0]       err_cnt
`endif
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] EXP_LO   = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] EXP_HI   = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [GW-1:0]    LOCK_VAL = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FIRST = 2'd1,
    ST_MEASURE    = 2'd2,
    ST_LOCKED     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [GW-1:0]    r_good_cnt;
  logic [GW-1:0]    w_good_nxt;
  logic [GW-1:0]    w_good_inc;
  logic [CNT_W-1:0] w_period_p;
  logic             w_report;
  logic             w_early;
  logic             w_late;

  logic [CNT_W-1:0] r_period;
  logic             r_period_valid;
  logic             r_locked;
  logic             r_err_early;
  logic             r_err_late;

  // cnt counts cycles since the last tick minus one, so the period is cnt+1.
  assign w_period_p = r_cnt + CNT_W'(1);
  assign w_good_inc = r_good_cnt + GW'(1);

  // Next-state, counter and event decode.
  always_comb begin
    w_next_state = r_state;
    w_cnt_nxt    = r_cnt;
    w_good_nxt   = r_good_cnt;
    w_report     = 1'b0;
    w_early      = 1'b0;
    w_late       = 1'b0;
    if (!enable) begin
      // enable low dominates everything, including a same-cycle tick
      w_next_state = ST_IDLE;
      w_cnt_nxt    = {CNT_W{1'b0}};
      w_good_nxt   = {GW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_next_state = ST_WAIT_FIRST;
          w_cnt_nxt    = {CNT_W{1'b0}};
          w_good_nxt   = {GW{1'b0}};
        end
        ST_WAIT_FIRST: begin
          w_cnt_nxt = {CNT_W{1'b0}};
          if (tick_in) begin
            w_next_state = ST_MEASURE;
          end else begin
            w_next_state = ST_WAIT_FIRST;
          end
        end
        ST_MEASURE, ST_LOCKED: begin
          if (tick_in) begin
            w_report  = 1'b1;
            w_cnt_nxt = {CNT_W{1'b0}};
            if (w_period_p < EXP_LO) begin
              w_early      = 1'b1;
              w_good_nxt   = {GW{1'b0}};
              w_next_state = ST_MEASURE;
            end else if (r_state == ST_LOCKED) begin
              w_next_state = ST_LOCKED;
            end else if (w_good_inc >= LOCK_VAL) begin
              w_good_nxt   = LOCK_VAL;
              w_next_state = ST_LOCKED;
            end else begin
              w_good_nxt   = w_good_inc;
              w_next_state = ST_MEASURE;
            end
          end else if (w_period_p == EXP_HI) begin
            // Deadline cycle without a tick: a later tick restarts measurement.
            w_late       = 1'b1;
            w_cnt_nxt    = {CNT_W{1'b0}};
            w_good_nxt   = {GW{1'b0}};
            w_next_state = ST_WAIT_FIRST;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_cnt_nxt    = {CNT_W{1'b0}};
          w_good_nxt   = {GW{1'b0}};
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= {CNT_W{1'b0}};
      r_good_cnt     <= {GW{1'b0}};
      r_period       <= {CNT_W{1'b0}};
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_err_early    <= 1'b0;
      r_err_late     <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_cnt          <= w_cnt_nxt;
      r_good_cnt     <= w_good_nxt;
      r_period       <= w_report ? w_period_p : r_period;
      r_period_valid <= w_report;
      r_locked       <= (w_next_state == ST_LOCKED);
      r_err_early    <= w_early;
      r_err_late     <= w_late;
    end
  end

  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign locked       = r_locked;
  assign err_early    = r_err_early;
  assign err_late     = r_err_late;

`ifdef TICK_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Saturating error counter; it steps on the same edge that raises err_*.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_cnt <= 8'd0;
    end else if (err_clr) begin
      r_err_cnt <= 8'd0;
    end else if ((w_early || w_late) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_tick_period_monitor.sv
// -----------------------------------------------------------------------------
// tb_tick_period_monitor
//   Two monitors (TOL=0 and TOL=1, EXP_PERIOD=3, LOCK_COUNT=4) share one
//   stimulus stream. A timestamp-based reference model pushes expected reports
//   and per-cycle locked state into queues; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_tick_period_monitor;

  localparam int CW    = 8;
  localparam int EXPP  = 3;
  localparam int LOCKN = 4;
  localparam int TOL0  = 0;
  localparam int TOL1  = 1;

  typedef struct {
    logic v;
    int   p;
    logic e;
    logic l;
  } ev_t;

  typedef struct {
    logic lk;
    int   ec;
  } cy_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          tick_in;
  logic          err_clr;
  logic [CW-1:0] period_o [2];
  logic          pv_o     [2];
  logic          lk_o     [2];
  logic          ee_o     [2];
  logic          el_o     [2];
  logic [7:0]    ec_o     [2];

  ev_t evq [2][$];
  cy_t cyq [2][$];
  int  m_idle [2];
  int  m_armed[2];
  int  m_last [2];
  int  m_strk [2];
  int  m_lock [2];
  int  m_ec   [2];
  int  cyc;
  bit  mon_en;
  int  checks;
  int  errors;

  always #5 clk = ~clk;

  tick_period_monitor #(.EXP_PERIOD(EXPP), .TOL(TOL0), .LOCK_COUNT(LOCKN), .CNT_W(CW)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .tick_in(tick_in),
    .period(period_o[0]), .period_valid(pv_o[0]), .locked(lk_o[0]),
    .err_early(ee_o[0]), .err_late(el_o[0])
`ifdef TICK_ERR_CNT_EN
    , .err_clr(err_clr), .err_cnt(ec_o[0])
`endif
  );

  tick_period_monitor #(.EXP_PERIOD(EXPP), .TOL(TOL1), .LOCK_COUNT(LOCKN), .CNT_W(CW)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .tick_in(tick_in),
    .period(period_o[1]), .period_valid(pv_o[1]), .locked(lk_o[1]),
    .err_early(ee_o[1]), .err_late(el_o[1])
`ifdef TICK_ERR_CNT_EN
    , .err_clr(err_clr), .err_cnt(ec_o[1])
`endif
  );

  function automatic int tol_of(input int i);
    return (i == 0) ? TOL0 : TOL1;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0d required=%0d (cycle %0d)", nm, i, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_idle[i]  = 1;
      m_armed[i] = 0;
      m_last[i]  = 0;
      m_strk[i]  = 0;
      m_lock[i]  = 0;
      m_ec[i]    = 0;
      evq[i].delete();
      cyq[i].delete();
    end
  endtask

  // Reference: expected behaviour from tick timestamps for the upcoming edge.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      ev_t ev;
      cy_t cy;
      int  gap;
      ev = '{v: 1'b0, p: 0, e: 1'b0, l: 1'b0};
      if (!enable) begin
        m_idle[i]  = 1;
        m_armed[i] = 0;
        m_strk[i]  = 0;
        m_lock[i]  = 0;
      end else if (m_idle[i] != 0) begin
        m_idle[i] = 0;
      end else if (m_armed[i] == 0) begin
        if (tick_in) begin
          m_armed[i] = 1;
          m_last[i]  = cyc;
        end
      end else begin
        gap = cyc - m_last[i];
        if (tick_in) begin
          ev.v = 1'b1;
          ev.p = gap;
          if (gap < EXPP - tol_of(i)) begin
            ev.e      = 1'b1;
            m_strk[i] = 0;
            m_lock[i] = 0;
          end else begin
            m_strk[i]++;
            if (m_strk[i] >= LOCKN) m_lock[i] = 1;
          end
          m_last[i] = cyc;
        end else if (gap == EXPP + tol_of(i)) begin
          ev.l       = 1'b1;
          m_armed[i] = 0;
          m_strk[i]  = 0;
          m_lock[i]  = 0;
        end
      end
      if (ev.v || ev.l) evq[i].push_back(ev);
      if (err_clr) m_ec[i] = 0;
      else if ((ev.e || ev.l) && m_ec[i] < 255) m_ec[i]++;
      cy.lk = (m_lock[i] != 0);
      cy.ec = m_ec[i];
      cyq[i].push_back(cy);
    end
    cyc++;
  endtask

  // Inputs are applied just after a rising edge; expectations are queued then.
  task automatic step(input logic en, input logic tk, input logic clr = 1'b0);
    enable  = en;
    tick_in = tk;
    err_clr = clr;
    model_step();
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  task automatic gap_tick(input int g);
    for (int k = 1; k < g; k++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_period"}, i, 32'(period_o[i]), 32'd0);
      chk({tag, "_period_valid"}, i, 32'(pv_o[i]), 32'd0);
      chk({tag, "_locked"}, i, 32'(lk_o[i]), 32'd0);
      chk({tag, "_err_early"}, i, 32'(ee_o[i]), 32'd0);
      chk({tag, "_err_late"}, i, 32'(el_o[i]), 32'd0);
`ifdef TICK_ERR_CNT_EN
      chk({tag, "_err_cnt"}, i, 32'(ec_o[i]), 32'd0);
`endif
    end
  endtask

  // Scoreboard monitor: per-cycle locked/err_cnt plus event reports.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        cy_t c;
        ev_t e;
        if (cyq[i].size() != 0) begin
          c = cyq[i].pop_front();
          chk("locked", i, 32'(lk_o[i]), 32'(c.lk));
`ifdef TICK_ERR_CNT_EN
          chk("err_cnt", i, 32'(ec_o[i]), 32'(c.ec));
`endif
        end
        if (pv_o[i] || ee_o[i] || el_o[i]) begin
          if (evq[i].size() == 0) begin
            chk("unexpected_event", i, {29'd0, pv_o[i], ee_o[i], el_o[i]}, 32'd0);
          end else begin
            e = evq[i].pop_front();
            chk("period_valid", i, 32'(pv_o[i]), 32'(e.v));
            if (e.v) chk("period", i, 32'(period_o[i]), 32'(e.p));
            chk("err_early", i, 32'(ee_o[i]), 32'(e.e));
            chk("err_late", i, 32'(el_o[i]), 32'(e.l));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int nxt;
    logic en;
    logic tk;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    enable  = 1'b0;
    tick_in = 1'b0;
    err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Lock-in with nominal spacing, then stay locked.
    for (int n = 0; n < 7; n++) gap_tick(3);
    // Early tick while locked, then relock.
    gap_tick(2);
    for (int n = 0; n < 5; n++) gap_tick(3);
    // Missing tick: timeout, then the late tick is a first tick.
    gap_tick(5);
    for (int n = 0; n < 6; n++) gap_tick(3);
    // One-cycle enable drop while locked, then relock.
    step(1'b0, 1'b0);
    for (int n = 0; n < 7; n++) gap_tick(3);
    // Enable low together with a tick.
    step(1'b0, 1'b1);
    for (int n = 0; n < 6; n++) gap_tick(3);
    // Back-to-back ticks.
    gap_tick(1);
    gap_tick(1);
    // Wider window on instance 1: spacing 2, 3, 4, then a gap of 4+.
    for (int n = 0; n < 3; n++) begin
      gap_tick(2);
      gap_tick(3);
      gap_tick(4);
    end
    gap_tick(6);
    for (int n = 0; n < 6; n++) gap_tick(3);

    // Asynchronous reset while locked, between clock edges.
    #2;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_zero("async_reset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 6; n++) gap_tick(3);

    // Randomized spacing with occasional enable drops.
    cnt = 0;
    nxt = 3;
    repeat (600) begin
      en = ($urandom_range(0, 39) != 0);
      cnt++;
      tk = (cnt >= nxt);
      if (tk) begin
        cnt = 0;
        nxt = ($urandom_range(0, 9) < 6) ? 3 : int'($urandom_range(1, 6));
      end
      step(en, tk, ($urandom_range(0, 99) == 0));
    end

`ifdef TICK_ERR_CNT_EN
    // Error count saturation, then clear colliding with an error.
    repeat (320) step(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
`endif

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    for (int i = 0; i < 2; i++) chk("events_drained", i, 32'(evq[i].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
